// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator between the CPU memory stage and a
// word-addressed data memory. The memory reads combinationally and writes
// whole words on the clock edge. Sub-word stores use read-modify-write.
// Misaligned, illegal-size and out-of-range requests get an error response
// and never reach the memory.
module dmem_lsu #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP
    } state_t;

    state_t      state, next_state;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;

    logic        accept;
    logic        req_err;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept   = req_valid & req_ready;
    assign mem_addr = {2'b00, addr_q[31:2]};

    // Request validation, evaluated on the unlatched inputs at acceptance
    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)
            req_err = 1'b1;
        if (req_size == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))
            req_err = 1'b1;
    end

    // Lane extraction and sign/zero extension of load data
    always_comb begin
        lane_b   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_ext = mem_rdata;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_ext = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_ext = mem_rdata;
        endcase
    end

    // Merge the store byte/half into the word read back from memory
    always_comb begin
        merged = mem_rdata;
        if (size_q == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        next_state = RESP;
                    else if (!req_we)
                        next_state = LOAD;
                    else if (req_size == 2'b10)
                        next_state = STORE;
                    else
                        next_state = RMW_RD;
                end
            end
            LOAD:    next_state = RESP;
            STORE:   next_state = RESP;
            RMW_RD:  next_state = RMW_WR;
            RMW_WR:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from state; reset gates every strobe immediately
    always_comb begin
        req_ready  = (state == IDLE) && !reset;
        resp_valid = (state == RESP) && !reset;
        mem_we     = ((state == STORE) || (state == RMW_WR)) && !reset;
        mem_wdata  = '0;
        if (!reset) begin
            if (state == STORE)
                mem_wdata = wdata_q;
            else if (state == RMW_WR)
                mem_wdata = merged_q;
        end
    end

    // Request latch, merge register and response registers; the response
    // registers are loaded on the edge entering RESP and then hold
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q       <= 1'b0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merged_q   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                if (req_err) begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b1;
                end
            end
            case (state)
                LOAD: begin
                    resp_rdata <= we_q ? '0 : load_ext;
                    resp_err   <= 1'b0;
                end
                STORE, RMW_WR: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                RMW_RD:  merged_q <= merged;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a behavioural word memory.
module tb_dmem_lsu;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    int          checks = 0;
    int          errors = 0;
    int          we_count = 0;
    int          resp_count = 0;

    dmem_lsu #(.MEM_WORDS(1024)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'h0;

    // Memory write port and event counters
    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_addr < 32'd1024)
                mem[mem_addr[9:0]] <= mem_wdata;
            we_count <= we_count + 1;
        end
        if (resp_valid)
            resp_count <= resp_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction: present, wait for acceptance, time the response
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                          input int exp_writes);
        int lat;
        int budget;
        int w0;
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        budget = 0;
        while (!req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        w0 = we_count;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        chk({tag, "_rdata"}, resp_rdata, exp_rdata);
        chk({tag, "_writes"}, 32'(we_count - w0), 32'(exp_writes));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
        chk({tag, "_hold"}, resp_rdata, exp_rdata);
    endtask

    logic [31:0] got [3];
    int          acc_cyc [3];
    int          idx;
    int          nresp;
    int          w0;
    int          r0;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", 32'(req_ready), 32'd1);

        // Word store/load
        do_req("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0, 1);
        chk("mem4_sw", mem[4], 32'hDEADBEEF);
        do_req("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF, 0);

        // Byte store via read-modify-write
        do_req("sb_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, 3, 1'b0, 32'h0, 1);
        chk("mem4_sb", mem[4], 32'hDEAD55EF);

        // Sub-word loads with extension
        do_req("lb_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 1'b0, 32'hFFFFFFDE, 0);
        do_req("lbu_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 1'b0, 32'h000000DE, 0);
        do_req("lh_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 1'b0, 32'hFFFFDEAD, 0);
        do_req("lhu_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 2, 1'b0, 32'h000055EF, 0);

        // Error responses
        do_req("sw_mis", 1'b1, 2'b10, 1'b0, 32'h12, 32'h11111111, 1, 1'b1, 32'h0, 0);
        chk("mem4_err", mem[4], 32'hDEAD55EF);
        do_req("size11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("lh_mis", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1, 1'b1, 32'h0, 0);
        do_req("lw_oor", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1, 1'b1, 32'h0, 0);

        // Last in-range word
        do_req("sw_ffc", 1'b1, 2'b10, 1'b0, 32'hFFC, 32'h12345678, 2, 1'b0, 32'h0, 1);
        do_req("lw_ffc", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 2, 1'b0, 32'h12345678, 0);

        // Upper-half store
        do_req("sh_12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, 3, 1'b0, 32'h0, 1);
        chk("mem4_sh", mem[4], 32'h123455EF);

        // Reset while in RMW_RD
        w0 = we_count; r0 = resp_count;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0000AAAA; req_valid = 1'b1;
        chk("rrd_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rrd_ready_after", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("rrd_writes", 32'(we_count - w0), 32'd0);
        chk("rrd_resps", 32'(resp_count - r0), 32'd0);
        chk("rrd_mem4", mem[4], 32'h123455EF);

        // Reset while in RMW_WR
        w0 = we_count; r0 = resp_count;
        req_valid = 1'b1;
        chk("rwr_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rwr_we_gated", 32'(mem_we), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rwr_ready_after", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("rwr_writes", 32'(we_count - w0), 32'd0);
        chk("rwr_resps", 32'(resp_count - r0), 32'd0);
        chk("rwr_mem4", mem[4], 32'h123455EF);

        // Back-to-back: lw 0x10, sb 0x77 at 0x10, lbu 0x10 with valid held high
        idx = 0; nresp = 0;
        for (int i = 0; i < 3; i++) begin
            acc_cyc[i] = -1;
            got[i] = 32'hFFFF_FFFF;
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (nresp < 3)
                    got[nresp] = resp_rdata;
                nresp++;
            end
            if (idx < 3) begin
                req_valid = 1'b1;
                req_addr  = 32'h10;
                req_wdata = 32'h00000077;
                req_we    = (idx == 1);
                req_size  = (idx == 0) ? 2'b10 : 2'b00;
                req_unsigned = 1'b1;
                if (req_ready) begin
                    acc_cyc[idx] = cyc;
                    idx++;
                end
            end else begin
                req_valid = 1'b0;
            end
        end
        chk("b2b_acc0", 32'(acc_cyc[0]), 32'd0);
        chk("b2b_acc1", 32'(acc_cyc[1]), 32'd3);
        chk("b2b_acc2", 32'(acc_cyc[2]), 32'd7);
        chk("b2b_nresp", 32'(nresp), 32'd3);
        chk("b2b_r0", got[0], 32'h123455EF);
        chk("b2b_r1", got[1], 32'h00000000);
        chk("b2b_r2", got[2], 32'h00000077);
        chk("b2b_mem4", mem[4], 32'h12345577);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store initiator that sits between the CPU memory stage and the word-addressed data memory.
- The data memory has a combinational read and a synchronous, full-word-only write.
- The block converts byte/halfword/word, signed/unsigned CPU accesses into word-memory cycles.
- Sub-word stores are done as read-modify-write.
- Misaligned and out-of-range accesses are rejected with an error response and never touch memory.

Parameters:
- MEM_WORDS, 1024: number of 32-bit words in the data memory; word index >= MEM_WORDS is out of range.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  CPU request valid
- req_ready  output  1  block can accept a request (IDLE only)
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address, little-endian
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load data (0 for stores and errors)
- resp_err  output  1  valid with resp_valid; misaligned/illegal/out-of-range
- mem_addr  output  32  word index to memory (byte address >> 2)
- mem_wdata  output  32  full word to write
- mem_we  output  1  memory write enable
- mem_rdata  input  32  combinational read data for mem_addr

Behaviour:
- Reset: clk, reset (synchronous, active-high) as decided.
  - State goes to IDLE; all latched request fields are cleared.
  - resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_wdata=0, mem_we=0.
  - mem_we is forced 0 in any cycle reset is high.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- req_ready=1 only in IDLE and not in reset. Acceptance = req_valid & req_ready; on acceptance all req_* fields are latched.
- Error check at acceptance; any one condition gives error:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= MEM_WORDS.
- Transitions out of IDLE on acceptance:
  - error -> RESP with err=1;
  - load -> LOAD;
  - word store -> STORE;
  - byte/half store -> RMW_RD.
- Memory-side drive: mem_addr is the latched addr[31:2] in all non-IDLE states and holds its last value in IDLE.
- LOAD:
  - Select the byte/half from mem_rdata by addr[1:0] (byte lane = addr[1:0], half lane = addr[1]).
  - Extend per req_unsigned and register into resp_rdata.
  - Go to RESP.
- STORE: mem_we=1, mem_wdata=req_wdata; go to RESP.
- RMW_RD:
  - Register merged word = mem_rdata with the addressed byte/half lane replaced by req_wdata[7:0]/[15:0].
  - Go to RMW_WR.
- RMW_WR: mem_we=1, mem_wdata=merged word; go to RESP.
- RESP:
  - resp_valid=1 for exactly this cycle.
  - resp_rdata holds load data (else 0); resp_err holds the error flag (else 0).
  - Next state is IDLE.
  - resp_rdata/resp_err hold their values until the next RESP or reset.
- Latency, counted from the acceptance edge to the cycle resp_valid is high: error 1 cycle, load 2, word store 2, sub-word store 3.
- Throughput: at most one outstanding request. The earliest next acceptance is the cycle after RESP.
- mem_we is high only in STORE/RMW_WR, exactly one cycle per store. It is never high for loads or errors.
- Reset mid-operation: the transaction is aborted, no response is issued, and no write is issued.
  - A reset asserted in RMW_WR suppresses that write.
  - req_ready=1 the cycle after reset deasserts.
- req_valid while not ready is ignored; the CPU must hold it.

Test Plan:
- Word store at 0x10, data 0xDEADBEEF, then word load at 0x10 -> memory word 4 = 0xDEADBEEF; each resp_valid 2 cycles after acceptance; load resp_rdata=0xDEADBEEF, resp_err=0.
- Byte store 0x55 at 0x11 over 0xDEADBEEF -> one RMW read then one mem_we cycle; word 4 = 0xDEAD55EF; resp_valid 3 cycles after acceptance.
- Loads from word 4 = 0xDEAD55EF:
  - signed byte at 0x13 -> 0xFFFFFFDE;
  - unsigned byte at 0x13 -> 0x000000DE;
  - signed half at 0x12 -> 0xFFFFDEAD;
  - unsigned half at 0x10 -> 0x000055EF.
- Errors:
  - word store at 0x12 -> resp_err=1 one cycle after acceptance, mem_we never high, word 4 unchanged;
  - size=11 -> err;
  - word load at 0x1000 (word 1024, MEM_WORDS=1024) -> err;
  - load at 0xFFC (word 1023) -> no error.
- Reset in RMW_RD/RMW_WR of a half store 0xAAAA at 0x10 -> no mem_we after reset, no resp_valid, req_ready=1 the cycle after reset deasserts.
- Back-to-back: req_valid held high with 3 queued requests -> req_ready low except in IDLE; exactly 3 resp_valid pulses in request order.
